// File: rtl/memstg_pkg.sv
// Shared definitions for the MEM-stage controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the controller state encoding and the WB control-bit positions
// already used by the MEM/WB pipeline register.
package memstg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } memstg_state_t;

  // Bit positions inside the WB control field carried by MEM/WB.
  localparam int WB_REGWRITE = 3;
  localparam int WB_MEMTOREG = 2;
  localparam int WB_PCTOREG  = 1;
  localparam int WB_HALT     = 0;

  localparam int MEMSTG_DW = 16;

endpackage

// File: rtl/memstg_timeout_cnt.sv
// Wait-state counter used to abandon a memory access that never completes.
// Latency: term is combinational from the current count and en.
// Backpressure: none; counts only while en is high, clr has priority.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       return count to zero
//   en        one more wait cycle has elapsed without completion
//   term      this enabled cycle brings the count up to LIMIT
module memstg_timeout_cnt #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Flag the cycle whose increment would reach LIMIT, so exactly LIMIT
  // wait cycles are spent before the access is dropped.
  assign term = en && (cnt == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores against a multi-cycle data memory.
// Latency: non-memory ops 0 cycles; memory ops stall 1 + memory wait cycles.
// Backpressure: stall freezes upstream stages while an access is outstanding.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   mem_read, mem_write    EX/MEM op type (both set = store)
//   flush                  squash the EX/MEM op (honoured in IDLE only)
//   addr, wdata            effective address and store data
//   dm_req/we/addr/wdata   registered request to data memory
//   dm_ready, dm_rdata     memory completion and read data
//   stall                  freeze PC, IF/ID, ID/EX, EX/MEM
//   mem_nop                bubble into MEM/WB
//   dmem_data              data into MEM/WB
//   mem_err                sticky timeout flag, cleared by rst only
//
// Optional macro MEMSTG_LAST_LOAD_EN: one-entry last-load buffer; a load
// that hits it completes from the buffer without a memory request.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        flush,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [15:0] dm_rdata,
  output logic        stall,
  output logic        mem_nop,
  output logic [15:0] dmem_data,
  output logic        mem_err
);

  import memstg_pkg::*;

  memstg_state_t state, state_nxt;

  logic        op;
  logic        ll_hit;
  logic [15:0] ll_dout;
  logic        tmo_en;
  logic        tmo_clr;
  logic        tmo_term;

  assign op = (mem_read | mem_write) & ~flush;

  // Counter runs only in WAIT cycles without completion and is cleared
  // everywhere else, so each access starts from zero.
  assign tmo_en  = (state == WAIT) & ~dm_ready;
  assign tmo_clr = (state != WAIT);

  memstg_timeout_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .term (tmo_term)
  );

`ifdef MEMSTG_LAST_LOAD_EN
  logic        ll_vld;
  logic [15:0] ll_addr;
  logic [15:0] ll_data;

  assign ll_hit  = op & mem_read & ~mem_write & ll_vld & (ll_addr == addr);
  assign ll_dout = ll_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ll_vld  <= 1'b0;
      ll_addr <= '0;
      ll_data <= '0;
    end else if ((state == IDLE) && op && mem_write) begin
      ll_vld <= 1'b0;
    end else if (state == WAIT) begin
      if (dm_ready && !dm_we) begin
        ll_vld  <= 1'b1;
        ll_addr <= dm_addr;
        ll_data <= dm_rdata;
      end else if (tmo_term) begin
        ll_vld <= 1'b0;
      end
    end
  end
`else
  assign ll_hit  = 1'b0;
  assign ll_dout = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_nop   = 1'b0;
    case (state)
      IDLE: begin
        if (op) begin
          stall     = 1'b1;
          mem_nop   = 1'b1;
          state_nxt = ll_hit ? DONE : WAIT;
        end else begin
          mem_nop = flush;
        end
      end
      WAIT: begin
        // Flush is deliberately ignored here: the access must finish.
        stall   = 1'b1;
        mem_nop = 1'b1;
        if (dm_ready || tmo_term) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // One open cycle lets MEM/WB capture the result; the op still in
        // EX/MEM is the one just served, so it is not reissued.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Release the pipeline immediately when an access is abandoned by reset.
    if (rst) begin
      stall   = 1'b0;
      mem_nop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      dmem_data <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op) begin
            if (ll_hit) begin
              dmem_data <= ll_dout;
            end else begin
              dm_req   <= 1'b1;
              dm_we    <= mem_write;
              dm_addr  <= addr;
              dm_wdata <= wdata;
            end
          end
        end
        WAIT: begin
          if (dm_ready) begin
            dm_req    <= 1'b0;
            dmem_data <= dm_we ? 16'h0000 : dm_rdata;
          end else if (tmo_term) begin
            dm_req    <= 1'b0;
            dmem_data <= '0;
            mem_err   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic        flush;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ready;
  logic [15:0] dm_rdata;
  logic        stall;
  logic        mem_nop;
  logic [15:0] dmem_data;
  logic        mem_err;

  mem_stage_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .flush     (flush),
    .addr      (addr),
    .wdata     (wdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ready  (dm_ready),
    .dm_rdata  (dm_rdata),
    .stall     (stall),
    .mem_nop   (mem_nop),
    .dmem_data (dmem_data),
    .mem_err   (mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        nop;
    logic [15:0] data;
    int          stalls;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  exp_t        ret_q[$];
  req_t        req_q[$];
  int          lat_q[$];
  logic [15:0] rdat_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state: result last handed to MEM/WB and sticky error.
  logic [15:0] m_data;
  logic        m_err;
`ifdef MEMSTG_LAST_LOAD_EN
  logic        m_ll_vld;
  logic [15:0] m_ll_addr;
  logic [15:0] m_ll_data;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Memory responder: completes each request on its planned wait cycle and
  // toggles dm_ready randomly while no request is outstanding.
  initial begin : responder
    bit          busy;
    int          cnt;
    int          lat;
    logic [15:0] dat;
    busy = 1'b0; cnt = 0; lat = 0; dat = '0;
    dm_ready = 1'b0;
    dm_rdata = '0;
    forever begin
      @(negedge clk);
      if (dm_req && !busy) begin
        busy = 1'b1;
        cnt  = 0;
        if (lat_q.size() > 0) begin
          lat = lat_q.pop_front();
          dat = rdat_q.pop_front();
        end else begin
          lat = 1000;
          dat = '0;
        end
      end
      if (dm_req) begin
        cnt++;
        dm_ready = (cnt == lat);
        dm_rdata = dm_ready ? dat : 16'($urandom);
      end else begin
        busy     = 1'b0;
        dm_ready = 1'($urandom_range(0, 1));
        dm_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: checks each new request and every cycle MEM/WB is open.
  initial begin : monitor
    int   run;
    bit   prev_req;
    req_t r;
    req_t cur;
    exp_t e;
    run = 0; prev_req = 1'b0;
    cur = '{we: 1'b0, addr: 16'h0, wdata: 16'h0};
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (dm_req && !prev_req) begin
          if (req_q.size() == 0) begin
            chk("spurious_dm_req", 32'(dm_req), 32'd0);
          end else begin
            r = req_q.pop_front();
            chk("dm_we", 32'(dm_we), 32'(r.we));
            chk("dm_addr", 32'(dm_addr), 32'(r.addr));
            if (r.we) chk("dm_wdata", 32'(dm_wdata), 32'(r.wdata));
            cur = r;
          end
        end else if (dm_req) begin
          chk("dm_addr_stable", 32'(dm_addr), 32'(cur.addr));
          chk("dm_we_stable", 32'(dm_we), 32'(cur.we));
        end
        if (stall) begin
          run++;
        end else begin
          if (ret_q.size() == 0) begin
            chk("unexpected_retire", 32'(ret_q.size()), 32'd1);
          end else begin
            e = ret_q.pop_front();
            chk("mem_nop", 32'(mem_nop), 32'(e.nop));
            chk("dmem_data", 32'(dmem_data), 32'(e.data));
            chk("stall_cycles", 32'(run), 32'(e.stalls));
            chk("mem_err", 32'(mem_err), 32'(e.err));
          end
          run = 0;
        end
      end else begin
        run = 0;
      end
      prev_req = dm_req;
    end
  end

  // Issue one EX/MEM instruction; lat is the wait cycle on which memory
  // answers (values above TMO never answer in time).
  task automatic issue(input logic rd, input logic wr, input logic fl,
                       input logic [15:0] a, input logic [15:0] wd,
                       input int lat, input logic [15:0] rdat, input bit wait_flush);
    exp_t e;
    req_t r;
    bit   op;
    bit   hit;
    int   n;
    op  = (rd || wr) && !fl;
    hit = 1'b0;
`ifdef MEMSTG_LAST_LOAD_EN
    hit = op && !wr && m_ll_vld && (m_ll_addr == a);
`endif
    if (!op) begin
      e.nop = fl; e.stalls = 0;
    end else if (hit) begin
`ifdef MEMSTG_LAST_LOAD_EN
      m_data = m_ll_data;
`endif
      e.nop = 1'b0; e.stalls = 1;
    end else begin
      r.we = wr; r.addr = a; r.wdata = wd;
      req_q.push_back(r);
      lat_q.push_back(lat);
      rdat_q.push_back(rdat);
      e.nop = 1'b0;
      if (lat <= TMO) begin
        e.stalls = 1 + lat;
        m_data   = wr ? 16'h0000 : rdat;
      end else begin
        e.stalls = 1 + TMO;
        m_data   = 16'h0000;
        m_err    = 1'b1;
      end
`ifdef MEMSTG_LAST_LOAD_EN
      if (wr || lat > TMO) m_ll_vld = 1'b0;
      else begin m_ll_vld = 1'b1; m_ll_addr = a; m_ll_data = rdat; end
`endif
    end
    e.data = m_data;
    e.err  = m_err;
    ret_q.push_back(e);

    mem_read = rd; mem_write = wr; flush = fl; addr = a; wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL stall_bound actual=%0d required<=40", n);
        break;
      end
      // From the first WAIT cycle on, upstream values must not matter.
      if (n >= 2) begin
        addr  = 16'($urandom);
        wdata = 16'($urandom);
        if (wait_flush) flush = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          k;
    logic        rd, wr, fl;
    logic [15:0] a;
    m_data = '0; m_err = 1'b0;
`ifdef MEMSTG_LAST_LOAD_EN
    m_ll_vld = 1'b0; m_ll_addr = '0; m_ll_data = '0;
`endif
    mem_read = 0; mem_write = 0; flush = 0; addr = '0; wdata = '0;
    rst = 1'b1;
    #1;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_dm_wdata", 32'(dm_wdata), 32'd0);
    chk("rst_dmem_data", 32'(dmem_data), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    mon_en = 1'b1;
    issue(1, 0, 0, 16'h0040, 16'h0000, 3, 16'hBEEF, 0);
    issue(0, 1, 0, 16'h0010, 16'h1234, 1, 16'h5555, 0);
    for (int i = 0; i < 4; i++) issue(0, 0, 0, 16'($urandom), 16'($urandom), 1, 16'h0, 0);
    issue(1, 0, 1, 16'h0020, 16'h0000, 1, 16'h7777, 0);
    issue(0, 0, 1, 16'h0000, 16'h0000, 1, 16'h0, 0);
    issue(1, 0, 0, 16'h0030, 16'h0000, 3, 16'hA5A5, 1);
    issue(1, 1, 0, 16'h0050, 16'h9999, 2, 16'h1111, 0);
    issue(1, 0, 0, 16'h0060, 16'h0000, 4, 16'h4444, 0);
    issue(1, 0, 0, 16'h0070, 16'h0000, 6, 16'h6666, 0);
    issue(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0, 0);
    issue(1, 0, 0, 16'h0040, 16'h0000, 2, 16'hC0DE, 0);
    issue(1, 0, 0, 16'h0040, 16'h0000, 2, 16'hD00D, 0);

    for (int i = 0; i < 150; i++) begin
      k  = int'($urandom_range(0, 9));
      a  = 16'($urandom_range(0, 3) * 16);
      rd = (k >= 3 && k <= 5) || k == 8 || k == 9;
      wr = (k == 6 || k == 7 || k == 8);
      fl = (k == 9) || (k <= 2 && $urandom_range(0, 1) == 1);
      issue(rd, wr, fl, a, 16'($urandom), int'($urandom_range(1, 6)),
            16'($urandom), 1'($urandom_range(0, 1)));
    end
    mon_en = 1'b0;

    // Reset in the middle of a WAIT abandons the access at once.
    lat_q.push_back(1000);
    rdat_q.push_back(16'h0);
    mem_read = 1; mem_write = 0; flush = 0; addr = 16'h0080;
    repeat (3) @(negedge clk);
    chk("pre_rst_dm_req", 32'(dm_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_dm_req", 32'(dm_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_mem_err", 32'(mem_err), 32'd0);
    chk("midrst_dmem_data", 32'(dmem_data), 32'd0);
    mem_read = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    lat_q.delete();
    rdat_q.delete();
    m_data = '0; m_err = 1'b0;
`ifdef MEMSTG_LAST_LOAD_EN
    m_ll_vld = 1'b0;
`endif
    @(posedge clk); #1;
    mon_en = 1'b1;
    issue(1, 0, 0, 16'h0040, 16'h0000, 2, 16'hCAFE, 0);
    issue(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0, 0);
    mon_en = 1'b0;
    mem_read = 0; mem_write = 0; flush = 0;

    repeat (3) @(negedge clk);
    chk("retire_q_empty", 32'(ret_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
